jump_sequencer: RTL and testbench

Program-counter sequencer for the lookup-driven branch scheme: holds the fetch PC, advances it each cycle, and, on a taken branch, indexes the jump table with the instruction's jump pointer and loads the returned target. It sits between the decoder/ALU (branch, condition, halt, stall) and instruction memory (PC, fetch-valid), and owns the jump table's address port. Taken branches cost one bubble cycle; a halt parks the sequencer until the next start.

---
 rtl/jump_sequencer.sv | 112 +++++++++++
 tb/tb_jump_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/jump_sequencer.sv
// Program-counter sequencer with jump-table branch resolution (one bubble per taken branch).
// Optional feature: define JUMP_RELATIVE_EN for pc-relative targets (default: absolute).
module jump_sequencer #(
    parameter int unsigned PC_W   = 10,
    parameter int unsigned JPTR_W = 6,
    parameter int unsigned LUT_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    input  logic              stall,
    input  logic              branch_en,
    input  logic              cond,
    input  logic              halt,
    input  logic [JPTR_W-1:0] jptr,
    output logic [JPTR_W-1:0] lut_addr,
    input  logic [LUT_W-1:0]  lut_data,
    output logic [PC_W-1:0]   pc,
    output logic              pc_valid,
    output logic              done,
    output logic [15:0]       branch_count
);

    if (PC_W < LUT_W) begin : g_width_check
        $error("jump_sequencer: PC_W must be >= LUT_W");
    end

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StRun     = 2'd1;
    localparam logic [1:0] StResolve = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [JPTR_W-1:0] lut_addr_q, lut_addr_d;
    logic [15:0]       count_q, count_d;
    logic              pc_valid_q, pc_valid_d;
    logic              done_q, done_d;
    logic [PC_W-1:0]   target;

`ifdef JUMP_RELATIVE_EN
    // pc still holds the branch's own address while in RESOLVE.
    assign target = pc_q + PC_W'($signed(lut_data));
`else
    assign target = PC_W'(lut_data);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        lut_addr_d = lut_addr_q;
        count_d    = count_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    pc_d    = start_pc;
                    count_d = 16'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // stall > halt > taken branch > sequential
                if (!stall) begin
                    if (halt) begin
                        state_d = StDone;
                    end else if (branch_en && cond) begin
                        lut_addr_d = jptr;
                        state_d    = StResolve;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            StResolve: begin
                pc_d    = target;
                state_d = StRun;
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        pc_valid_d = (state_d == StRun);
        done_d     = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            lut_addr_q <= '0;
            count_q    <= 16'd0;
            pc_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            lut_addr_q <= lut_addr_d;
            count_q    <= count_d;
            pc_valid_q <= pc_valid_d;
            done_q     <= done_d;
        end
    end

    assign pc           = pc_q;
    assign lut_addr     = lut_addr_q;
    assign branch_count = count_q;
    assign pc_valid     = pc_valid_q;
    assign done         = done_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// Scoreboard bench for jump_sequencer: directed scenarios plus randomized traffic.
module tb_jump_sequencer;
    localparam int PC_W   = 10;
    localparam int JPTR_W = 6;
    localparam int LUT_W  = 6;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start, stall, branch_en, cond, halt;
    logic [PC_W-1:0]   start_pc;
    logic [JPTR_W-1:0] jptr, lut_addr;
    logic [LUT_W-1:0]  lut_data;
    logic [PC_W-1:0]   pc;
    logic              pc_valid, done;
    logic [15:0]       branch_count;

    logic [LUT_W-1:0]  jt [1<<JPTR_W];
    assign lut_data = jt[lut_addr];

    always #5 clk = ~clk;

    jump_sequencer #(.PC_W(PC_W), .JPTR_W(JPTR_W), .LUT_W(LUT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_pc(start_pc),
        .stall(stall), .branch_en(branch_en), .cond(cond), .halt(halt),
        .jptr(jptr), .lut_addr(lut_addr), .lut_data(lut_data), .pc(pc),
        .pc_valid(pc_valid), .done(done), .branch_count(branch_count)
    );

    typedef struct {
        int pc;
        bit valid;
        bit dn;
        int la;
        int cnt;
    } exp_t;

    typedef enum {MIdle, MRun, MResolve, MDone} mode_t;

    exp_t  sb[$];
    int    tests = 0;
    int    fails = 0;
    mode_t m_mode;
    int    m_pc, m_lut, m_cnt;

    function automatic int jump_target(int cur, int entry);
`ifdef JUMP_RELATIVE_EN
        int s;
        s = (entry >= (1 << (LUT_W - 1))) ? entry - (1 << LUT_W) : entry;
        return (cur + s + (1 << PC_W)) % (1 << PC_W);
`else
        return entry;
`endif
    endfunction

    task automatic model_reset();
        m_mode = MIdle;
        m_pc   = 0;
        m_lut  = 0;
        m_cnt  = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // One cycle of stimulus; the model predicts the outputs after the next rising edge.
    task automatic cyc(input bit st, input int spc, input bit stl, input bit be,
                       input bit cd, input bit hl, input int jp);
        exp_t e;
        @(negedge clk);
        start     = st;
        start_pc  = spc[PC_W-1:0];
        stall     = stl;
        branch_en = be;
        cond      = cd;
        halt      = hl;
        jptr      = jp[JPTR_W-1:0];
        case (m_mode)
            MIdle, MDone: if (st) begin
                m_pc   = spc % (1 << PC_W);
                m_cnt  = 0;
                m_mode = MRun;
            end
            MRun: if (!stl) begin
                if (hl) m_mode = MDone;
                else if (be && cd) begin
                    m_lut  = jp % (1 << JPTR_W);
                    m_mode = MResolve;
                end else m_pc = (m_pc + 1) % (1 << PC_W);
            end
            MResolve: begin
                m_pc   = jump_target(m_pc, int'(jt[m_lut]));
                m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                m_mode = MRun;
            end
            default: ;
        endcase
        e.pc    = m_pc;
        e.valid = (m_mode == MRun);
        e.dn    = (m_mode == MDone);
        e.la    = m_lut;
        e.cnt   = m_cnt;
        sb.push_back(e);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            tests++;
            if (int'(pc) != e.pc || pc_valid !== e.valid || done !== e.dn ||
                int'(lut_addr) != e.la || int'(branch_count) != e.cnt) begin
                fails++;
                $display("FAIL cycle t=%0t got pc=%0h v=%0b d=%0b la=%0h cnt=%0h expected pc=%0h v=%0b d=%0b la=%0h cnt=%0h",
                         $time, pc, pc_valid, done, lut_addr, branch_count,
                         e.pc, e.valid, e.dn, e.la, e.cnt);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        {start, stall, branch_en, cond, halt} = '0;
        start_pc = '0;
        jptr     = '0;
        for (int i = 0; i < (1 << JPTR_W); i++) jt[i] = LUT_W'($urandom);
        jt[3] = 6'd20;
        jt[9] = 6'b111110;
        model_reset();
        #1;
        chk("reset_pc", int'(pc), 0);
        chk("reset_valid", int'(pc_valid), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_lut_addr", int'(lut_addr), 0);
        chk("reset_count", int'(branch_count), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // sequential from 0
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (5) idle();
        // wrap at top of address space
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 'h3fd, 0, 0, 0, 0, 0);
        repeat (4) idle();
        // taken branch through table[3]
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 4, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 3);
        idle();
        idle();
        // negative table entry
        cyc(0, 0, 0, 1, 1, 0, 9);
        cyc(1, 0, 1, 1, 1, 1, 5);
        idle();
        // halt beats taken branch
        cyc(0, 0, 0, 1, 1, 1, 5);
        idle();
        idle();
        // stall beats halt
        cyc(1, 100, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 1, 1, 2);
        cyc(0, 0, 0, 0, 0, 1, 0);
        // untaken branch and start while running
        cyc(1, 50, 0, 0, 0, 0, 0);
        cyc(1, 9, 0, 1, 0, 0, 7);
        cyc(1, 9, 0, 1, 0, 0, 7);
        // saturation via preload
        cyc(0, 0, 1, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        force dut.count_q = 16'hfffd;
        #1;
        release dut.count_q;
        m_cnt = 16'hfffd;
        repeat (3) begin
            cyc(0, 0, 0, 1, 1, 0, 3);
            idle();
        end

        // randomized traffic
        repeat (3000) begin
            bit st;
            st = (m_mode == MIdle || m_mode == MDone) ? ($urandom_range(0, 3) == 0)
                                                      : ($urandom_range(0, 19) == 0);
            cyc(st, int'($urandom_range(0, (1 << PC_W) - 1)), $urandom_range(0, 6) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 24) == 0, int'($urandom_range(0, (1 << JPTR_W) - 1)));
        end

        // reset in the middle of RESOLVE
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 'h10, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 3);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_pc", int'(pc), 0);
        chk("midreset_valid", int'(pc_valid), 0);
        chk("midreset_lut_addr", int'(lut_addr), 0);
        chk("midreset_count", int'(branch_count), 0);
        chk("midreset_done", int'(done), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1, 7, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("restart_pc", int'(pc), 7);
        chk("restart_count", int'(branch_count), 0);
        idle();
        @(posedge clk);
        #3;
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
